// File: rtl/data_mem_bridge.sv
// Registered bridge from the data memory controller to a strobe/ack memory bus.
// One outstanding request; completes with a single Ready pulse or a timeout error.
module data_mem_bridge #(
  parameter int TIMEOUT   = 1023,
  parameter int CNT_WIDTH = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic        ReadEnable,
  input  logic [3:0]  WriteEnable,
  input  logic [31:0] MWriteData,
  output logic [31:0] MReadData,
  output logic        DataMem_Ready,
  output logic        Bus_Error,
  output logic [29:0] Mem_Address,
  output logic [31:0] Mem_WriteData,
  output logic [3:0]  Mem_ByteSel,
  output logic        Mem_We,
  output logic        Mem_Stb,
  input  logic        Mem_Ack,
  input  logic [31:0] Mem_ReadData
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_RESP,
    S_HOLD
  } state_t;

  localparam logic [CNT_WIDTH-1:0] TERM =
    CNT_WIDTH'(TIMEOUT - 1);

  state_t               r_state;
  state_t               w_next;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [31:0]          r_rdata;
  logic                 r_ready;
  logic                 r_err;
  logic [29:0]          r_addr;
  logic [31:0]          r_wdata;
  logic [3:0]           r_bsel;
  logic                 r_we;
  logic                 r_stb;
  logic                 w_req;
  logic                 w_wr;
  logic                 w_term;
  logic                 w_unused;

  assign w_wr     = |WriteEnable;
  assign w_req    = ReadEnable | w_wr;
  assign w_term   = (TIMEOUT != 0) && (r_cnt == TERM);
  assign w_unused = &{1'b0, Address[1:0]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_req) w_next = S_BUS;
      S_BUS:  if (Mem_Ack || w_term) w_next = S_RESP;
      S_RESP: w_next = S_HOLD;
      S_HOLD: if (!w_req) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_rdata <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_bsel  <= '0;
      r_we    <= 1'b0;
      r_stb   <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_addr  <= Address[31:2];
            r_wdata <= MWriteData;
            r_we    <= w_wr;
            r_bsel  <= w_wr ? WriteEnable : 4'hF;
            r_stb   <= 1'b1;
            r_cnt   <= '0;
          end
        end
        S_BUS: begin
          // ack beats the terminal count when both land together
          if (Mem_Ack) begin
            if (!r_we) r_rdata <= Mem_ReadData;
            r_stb   <= 1'b0;
            r_ready <= 1'b1;
          end else if (w_term) begin
            r_rdata <= '0;
            r_stb   <= 1'b0;
            r_ready <= 1'b1;
            r_err   <= 1'b1;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign MReadData     = r_rdata;
  assign DataMem_Ready = r_ready;
  assign Bus_Error     = r_err;
  assign Mem_Address   = r_addr;
  assign Mem_WriteData = r_wdata;
  assign Mem_ByteSel   = r_bsel;
  assign Mem_We        = r_we;
  assign Mem_Stb       = r_stb;

endmodule

// File: tb/tb_data_mem_bridge.sv
// Directed bench for data_mem_bridge: default-timeout instance (a)
// and a TIMEOUT=4 instance (b) sharing the request side.
module tb_data_mem_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic        rd = 1'b0;
  logic [3:0]  we = '0;
  logic [31:0] wdata = '0;
  logic [31:0] mrd = '0;
  logic        ack_a = 1'b0;
  logic        ack_b = 1'b0;
  logic        sel = 1'b0;

  logic [31:0] rdata_a, wd_a, rdata_b, wd_b;
  logic [29:0] ma_a, ma_b;
  logic [3:0]  bs_a, bs_b;
  logic        rdy_a, err_a, mwe_a, stb_a;
  logic        rdy_b, err_b, mwe_b, stb_b;

  logic [31:0] s_rdata, s_wd;
  logic [29:0] s_ma;
  logic [3:0]  s_bs;
  logic        s_rdy, s_err, s_mwe, s_stb;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  data_mem_bridge u_a (
    .clock(clk), .reset(rst_n), .Address(addr),
    .ReadEnable(rd), .WriteEnable(we), .MWriteData(wdata),
    .MReadData(rdata_a), .DataMem_Ready(rdy_a), .Bus_Error(err_a),
    .Mem_Address(ma_a), .Mem_WriteData(wd_a), .Mem_ByteSel(bs_a),
    .Mem_We(mwe_a), .Mem_Stb(stb_a), .Mem_Ack(ack_a),
    .Mem_ReadData(mrd)
  );

  data_mem_bridge #(.TIMEOUT(4), .CNT_WIDTH(3)) u_b (
    .clock(clk), .reset(rst_n), .Address(addr),
    .ReadEnable(rd), .WriteEnable(we), .MWriteData(wdata),
    .MReadData(rdata_b), .DataMem_Ready(rdy_b), .Bus_Error(err_b),
    .Mem_Address(ma_b), .Mem_WriteData(wd_b), .Mem_ByteSel(bs_b),
    .Mem_We(mwe_b), .Mem_Stb(stb_b), .Mem_Ack(ack_b),
    .Mem_ReadData(mrd)
  );

  assign s_rdata = sel ? rdata_b : rdata_a;
  assign s_wd    = sel ? wd_b : wd_a;
  assign s_ma    = sel ? ma_b : ma_a;
  assign s_bs    = sel ? bs_b : bs_a;
  assign s_rdy   = sel ? rdy_b : rdy_a;
  assign s_err   = sel ? err_b : err_a;
  assign s_mwe   = sel ? mwe_b : mwe_a;
  assign s_stb   = sel ? stb_b : stb_a;

  typedef struct {
    string       name;
    logic        sel;
    logic        rd;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ack_cyc;
    logic [31:0] mrd;
    int          exp_ready;
    int          exp_err;
    logic [29:0] exp_ma;
    logic [3:0]  exp_bs;
    logic        exp_we;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    ack_a = 1'b0;
    ack_b = 1'b0;
    rd = 1'b0;
    we = '0;
    repeat (n) tick();
  endtask

  task automatic run_vec(input vec_t v);
    int rcyc = 0;
    int npulse = 0;
    int nerr = 0;
    int nstb = 0;
    int unstable = 0;
    logic [31:0] rd_at = '0;
    sel = v.sel;
    tick();
    addr = v.addr;
    rd = v.rd;
    we = v.we;
    wdata = v.wdata;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      tick();
      if (s_stb) begin
        nstb++;
        if (s_ma !== v.exp_ma || s_bs !== v.exp_bs ||
            s_mwe !== v.exp_we || s_wd !== v.wdata)
          unstable++;
      end
      if (s_rdy) begin
        if (rcyc == 0) rcyc = cyc;
        npulse++;
        rd_at = s_rdata;
      end
      if (s_err) nerr++;
      mrd = v.mrd;
      ack_a = !v.sel && (cyc == v.ack_cyc);
      ack_b = v.sel && (cyc == v.ack_cyc);
      if (rcyc != 0 && cyc == rcyc + 2) break;
    end
    chk({v.name, "_ready_cyc"}, 64'(rcyc), 64'(v.exp_ready));
    chk({v.name, "_pulses"}, 64'(npulse), 64'd1);
    chk({v.name, "_err"}, 64'(nerr), 64'(v.exp_err));
    chk({v.name, "_stb_cycles"}, 64'(nstb), 64'(v.exp_ready - 1));
    chk({v.name, "_stable"}, 64'(unstable), 64'd0);
    chk({v.name, "_rdata"}, 64'(rd_at), 64'(v.exp_rdata));
    idle(2);
  endtask

  initial begin
    vecs[0] = '{"rd0wait", 1'b0, 1'b1, 4'h0, 32'h0000_1004, 32'h0,
                1, 32'hDEAD_BEEF, 2, 0, 30'h401, 4'hF, 1'b0,
                32'hDEAD_BEEF};
    vecs[1] = '{"wr5wait", 1'b0, 1'b0, 4'b0100, 32'h0000_2008,
                32'h00AB_0000, 5, 32'h5555_5555, 6, 0, 30'h802,
                4'b0100, 1'b1, 32'hDEAD_BEEF};
    vecs[2] = '{"conflict", 1'b0, 1'b1, 4'b0011, 32'h0000_0030,
                32'h0000_1234, 2, 32'h6666_6666, 3, 0, 30'hC,
                4'b0011, 1'b1, 32'hDEAD_BEEF};
    vecs[3] = '{"rdtop", 1'b0, 1'b1, 4'h0, 32'hFFFF_FFFF, 32'h0,
                3, 32'hCAFE_F00D, 4, 0, 30'h3FFF_FFFF, 4'hF, 1'b0,
                32'hCAFE_F00D};
    vecs[4] = '{"ackterm", 1'b1, 1'b1, 4'h0, 32'h0000_0200, 32'h0,
                4, 32'h1234_5678, 5, 0, 30'h80, 4'hF, 1'b0,
                32'h1234_5678};
    vecs[5] = '{"timeout", 1'b1, 1'b1, 4'h0, 32'h0000_0300, 32'h0,
                0, 32'h9999_9999, 5, 1, 30'hC0, 4'hF, 1'b0,
                32'h0};

    repeat (3) tick();
    chk("rst_rdata_a", 64'(rdata_a), 64'd0);
    chk("rst_addr_a", 64'(ma_a), 64'd0);
    chk("rst_wdata_a", 64'(wd_a), 64'd0);
    chk("rst_ctl_a", 64'({rdy_a, err_a, mwe_a, stb_a, bs_a}), 64'd0);
    chk("rst_ctl_b", 64'({rdy_b, err_b, mwe_b, stb_b, bs_b, rdata_b}),
        64'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // back-to-back: ack held high through HOLD/IDLE must be ignored
    sel = 1'b0;
    addr = 32'h40; rd = 1'b1;
    tick();
    chk("b2b_stb1", 64'(stb_a), 64'd1);
    mrd = 32'h1111_2222; ack_a = 1'b1;
    tick();
    chk("b2b_ready2", 64'(rdy_a), 64'd1);
    chk("b2b_rdata", 64'(rdata_a), 64'h1111_2222);
    ack_a = 1'b0;
    tick();
    chk("b2b_hold", 64'({rdy_a, stb_a}), 64'd0);
    rd = 1'b0; ack_a = 1'b1; mrd = 32'hBAD0_BAD0;
    tick();
    chk("b2b_idle", 64'({rdy_a, stb_a}), 64'd0);
    addr = 32'h44; we = 4'hF; wdata = 32'hA5A5_A5A5;
    tick();
    chk("b2b_wr_stb", 64'({rdy_a, stb_a, mwe_a, bs_a}), 64'h3F);
    chk("b2b_wr_addr", 64'(ma_a), 64'h11);
    chk("b2b_wr_data", 64'(wd_a), 64'hA5A5_A5A5);
    tick();
    chk("b2b_wr_ready", 64'({rdy_a, err_a}), 64'h2);
    chk("b2b_wr_rdata", 64'(rdata_a), 64'h1111_2222);
    idle(3);

    // async reset in the middle of a wait-state read
    addr = 32'h100; rd = 1'b1;
    tick();
    chk("rst_mid_stb1", 64'(stb_a), 64'd1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_async", 64'({rdy_a, stb_a, ma_a}), 64'd0);
    tick();
    chk("rst_mid_held", 64'({rdy_a, stb_a}), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_reissue", 64'({rdy_a, stb_a, ma_a}), 64'({2'b01, 30'h40}));
    mrd = 32'h7777_8888; ack_a = 1'b1;
    tick();
    chk("rst_reissue_rdy", 64'(rdy_a), 64'd1);
    chk("rst_reissue_rd", 64'(rdata_a), 64'h7777_8888);
    idle(8);

    for (int i = 4; i < 6; i++) run_vec(vecs[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
